// File: rtl/ex_muldiv_unit.sv
// Multi-cycle unsigned MUL/DIV execution unit with operand forwarding muxes.
// Shift-add multiply and restoring divide, one bit per cycle, stalling the pipeline while busy.
module ex_muldiv_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      IDEXIR,
  input  logic [2:0]       ForwardA,
  input  logic [2:0]       ForwardB,
  input  logic [WIDTH-1:0] rf_a,
  input  logic [WIDTH-1:0] rf_b,
  input  logic [WIDTH-1:0] exmem_alu,
  input  logic [WIDTH-1:0] exmem_r0_mul,
  input  logic [WIDTH-1:0] exmem_r0_div,
  input  logic [WIDTH-1:0] memwb_wdata,
  input  logic [WIDTH-1:0] memwb_r0_mul,
  input  logic [WIDTH-1:0] memwb_r0_div,
  input  logic             flush,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] a_r, b_r, hi_r, lo_r;
  logic [WIDTH-1:0] hi_nxt_s, lo_nxt_s;
  logic [WIDTH:0]   sum_s, shifted_s, trial_s;
  logic             is_mul_s, is_div_s, start_s, opb_zero_s, last_s;

  // Forwarding muxes for both operands
  always_comb begin
    case (ForwardA)
      3'd0:    op_a = exmem_r0_mul;
      3'd1:    op_a = exmem_r0_div;
      3'd2:    op_a = exmem_alu;
      3'd3:    op_a = memwb_wdata;
      3'd4:    op_a = memwb_r0_mul;
      3'd5:    op_a = memwb_r0_div;
      default: op_a = rf_a;
    endcase
    case (ForwardB)
      3'd0:    op_b = exmem_r0_mul;
      3'd1:    op_b = exmem_r0_div;
      3'd2:    op_b = exmem_alu;
      3'd3:    op_b = memwb_wdata;
      3'd4:    op_b = memwb_r0_mul;
      3'd5:    op_b = memwb_r0_div;
      default: op_b = rf_b;
    endcase
  end

  // Instruction decode; a flushed instruction never starts
  always_comb begin
    is_mul_s   = (IDEXIR[15:12] == 4'd0) && (IDEXIR[3:0] == 4'd4);
    is_div_s   = (IDEXIR[15:12] == 4'd0) && (IDEXIR[3:0] == 4'd5);
    start_s    = (is_mul_s || is_div_s) && !flush;
    opb_zero_s = (op_b == {WIDTH{1'b0}});
    last_s     = (cnt_r == LAST);
  end

  // One iteration of the shared hi/lo datapath: multiply shifts right, divide shifts left
  always_comb begin
    sum_s     = {1'b0, hi_r} + {1'b0, (lo_r[0] ? a_r : {WIDTH{1'b0}})};
    shifted_s = {hi_r, lo_r[WIDTH-1]};
    trial_s   = shifted_s - {1'b0, b_r};
    if (state_r == MUL) begin
      hi_nxt_s = sum_s[WIDTH:1];
      lo_nxt_s = {sum_s[0], lo_r[WIDTH-1:1]};
    end else if (state_r == DIV) begin
      if (shifted_s >= {1'b0, b_r}) begin
        hi_nxt_s = trial_s[WIDTH-1:0];
        lo_nxt_s = {lo_r[WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt_s = shifted_s[WIDTH-1:0];
        lo_nxt_s = {lo_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_nxt_s = hi_r;
      lo_nxt_s = lo_r;
    end
  end

  // Next-state and stall; stall covers the start cycle unless it is a divide by zero
  always_comb begin
    state_s = state_r;
    stall   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          if (is_mul_s) begin
            state_s = MUL;
            stall   = 1'b1;
          end else if (opb_zero_s) begin
            state_s = DONE;
            stall   = 1'b0;
          end else begin
            state_s = DIV;
            stall   = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      MUL, DIV: begin
        stall = 1'b1;
        if (flush) begin
          state_s = IDLE;
        end else if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = state_r;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
    if (rst) begin
      stall = 1'b0;
    end else begin
      stall = stall;
    end
  end

  assign done = (state_r == DONE);

  // State, operand capture, iteration and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= {CW{1'b0}};
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
      result_lo <= {WIDTH{1'b0}};
      result_hi <= {WIDTH{1'b0}};
      div_zero  <= 1'b0;
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (start_s) begin
            a_r      <= op_a;
            b_r      <= op_b;
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= is_mul_s ? op_b : op_a;
            cnt_r    <= {CW{1'b0}};
            div_zero <= 1'b0;
            if (is_div_s && opb_zero_s) begin
              result_lo <= {WIDTH{1'b1}};
              result_hi <= op_a;
              div_zero  <= 1'b1;
            end
          end
        end
        MUL, DIV: begin
          hi_r  <= hi_nxt_s;
          lo_r  <= lo_nxt_s;
          cnt_r <= cnt_r + CW'(1);
          if (last_s && !flush) begin
            result_lo <= lo_nxt_s;
            result_hi <= hi_nxt_s;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: randomized MUL/DIV against an arithmetic reference model.
module tb_ex_muldiv_unit;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   IDEXIR;
  logic [2:0]    ForwardA, ForwardB;
  logic [W-1:0]  rf_a, rf_b, exmem_alu, exmem_r0_mul, exmem_r0_div;
  logic [W-1:0]  memwb_wdata, memwb_r0_mul, memwb_r0_div;
  logic          flush;
  logic [W-1:0]  op_a, op_b, result_lo, result_hi;
  logic          stall, done, div_zero;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dz;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  ex_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .IDEXIR(IDEXIR), .ForwardA(ForwardA), .ForwardB(ForwardB),
    .rf_a(rf_a), .rf_b(rf_b), .exmem_alu(exmem_alu), .exmem_r0_mul(exmem_r0_mul),
    .exmem_r0_div(exmem_r0_div), .memwb_wdata(memwb_wdata), .memwb_r0_mul(memwb_r0_mul),
    .memwb_r0_div(memwb_r0_div), .flush(flush), .op_a(op_a), .op_b(op_b), .stall(stall),
    .done(done), .result_lo(result_lo), .result_hi(result_hi), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
  endtask

  // Operand source table in the order of the select codes
  function automatic logic [W-1:0] sel_model(input logic [2:0] code, input logic [W-1:0] rf);
    logic [W-1:0] srcs [8];
    srcs = '{exmem_r0_mul, exmem_r0_div, exmem_alu, memwb_wdata,
             memwb_r0_mul, memwb_r0_div, rf, rf};
    return srcs[code];
  endfunction

  task automatic rand_src();
    rf_a = W'($urandom); rf_b = W'($urandom);
    exmem_alu = W'($urandom); exmem_r0_mul = W'($urandom); exmem_r0_div = W'($urandom);
    memwb_wdata = W'($urandom); memwb_r0_mul = W'($urandom); memwb_r0_div = W'($urandom);
  endtask

  task automatic set_src(input logic [2:0] code, input logic [W-1:0] val, input bit is_b);
    case (code)
      3'd0: exmem_r0_mul = val;
      3'd1: exmem_r0_div = val;
      3'd2: exmem_alu = val;
      3'd3: memwb_wdata = val;
      3'd4: memwb_r0_mul = val;
      3'd5: memwb_r0_div = val;
      default: if (is_b) rf_b = val; else rf_a = val;
    endcase
  endtask

  function automatic logic [15:0] instr(input logic [3:0] opc, input logic [3:0] fn);
    return {opc, 8'($urandom), fn};
  endfunction

  // Issue one operation in the current cycle and follow it until the IDLE cycle after done
  task automatic run_op(input bit is_div, input bit flush_done);
    logic [W-1:0]   a, b;
    logic [2*W-1:0] p;
    exp_t           e;
    int             lat;
    a = sel_model(ForwardA, rf_a);
    b = sel_model(ForwardB, rf_b);
    e.dz = is_div && (b == '0);
    if (e.dz) begin
      e.lo = '1; e.hi = a;
    end else if (is_div) begin
      e.lo = a / b; e.hi = a % b;
    end else begin
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      e.lo = p[W-1:0]; e.hi = p[2*W-1:W];
    end
    lat = e.dz ? 1 : W + 1;
    e.cyc = cyc + lat;
    sb.push_back(e);
    IDEXIR = instr(4'h0, is_div ? 4'h5 : 4'h4);
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      chk("stall", 64'(stall), 64'(!e.dz && k <= W));
      @(posedge clk);
      #1;
      if (k == 0) begin
        IDEXIR = instr(4'h1, 4'h4);
        rand_src();
      end
      flush = flush_done && (k + 1 == lat);
    end
    flush = 1'b0;
  endtask

  // Scoreboard monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL spurious_done cycle=%0d actual done=1 required done=0", cyc);
      end else begin
        e = sb.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
        chk("result_lo", 64'(result_lo), 64'(e.lo));
        chk("result_hi", 64'(result_hi), 64'(e.hi));
        chk("div_zero", 64'(div_zero), 64'(e.dz));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout cycle=%0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; ForwardA = 3'd6; ForwardB = 3'd6;
    IDEXIR = instr(4'h1, 4'h5);
    rand_src();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_lo", 64'(result_lo), 64'd0);
    chk("rst_hi", 64'(result_hi), 64'd0);
    chk("rst_dz", 64'(div_zero), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Forwarding select sweep
    for (int c = 0; c < 8; c++) begin
      rand_src();
      ForwardA = 3'(c);
      ForwardB = 3'(7 - c);
      #1;
      chk("op_a_sel", 64'(op_a), 64'(sel_model(ForwardA, rf_a)));
      chk("op_b_sel", 64'(op_b), 64'(sel_model(ForwardB, rf_b)));
    end
    @(posedge clk); #1;

    ForwardA = 3'd6; ForwardB = 3'd6; rf_a = 16'h1234; rf_b = 16'h0010;
    run_op(1'b0, 1'b0);
    chk("mul_1234_hi", 64'(result_hi), 64'h0001);
    chk("mul_1234_lo", 64'(result_lo), 64'h2340);

    ForwardA = 3'd6; ForwardB = 3'd6; rf_a = 16'hFFFF; rf_b = 16'hFFFF;
    run_op(1'b0, 1'b1);
    chk("mul_ffff_hi", 64'(result_hi), 64'hFFFE);
    chk("mul_ffff_lo", 64'(result_lo), 64'h0001);

    ForwardA = 3'd2; exmem_alu = 16'd100; ForwardB = 3'd4; memwb_r0_mul = 16'd7;
    run_op(1'b1, 1'b0);
    chk("div_100_7_q", 64'(result_lo), 64'h000E);
    chk("div_100_7_r", 64'(result_hi), 64'h0002);
    chk("div_100_7_dz", 64'(div_zero), 64'd0);

    ForwardA = 3'd6; ForwardB = 3'd6; rf_a = 16'h00AB; rf_b = 16'h0000;
    run_op(1'b1, 1'b0);
    chk("divz_lo", 64'(result_lo), 64'hFFFF);
    chk("divz_hi", 64'(result_hi), 64'h00AB);
    chk("divz_flag", 64'(div_zero), 64'd1);

    // MUL flushed in its fifth busy cycle; div_zero clears at this start
    rf_a = 16'h0F0F; rf_b = 16'h0303;
    IDEXIR = instr(4'h0, 4'h4);
    @(posedge clk); #1;
    IDEXIR = instr(4'h1, 4'h4);
    @(negedge clk);
    chk("dz_clear_on_start", 64'(div_zero), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_cycle_stall", 64'(stall), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("after_flush_stall", 64'(stall), 64'd0);
    repeat (20) @(posedge clk);
    #1;

    rand_src(); ForwardA = 3'd3; ForwardB = 3'd5;
    run_op(1'b0, 1'b0);

    // Reset in the middle of a DIV
    ForwardA = 3'd6; ForwardB = 3'd6; rf_a = 16'hBEEF; rf_b = 16'h0013;
    IDEXIR = instr(4'h0, 4'h5);
    @(posedge clk); #1;
    IDEXIR = instr(4'h1, 4'h5);
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("midrst_stall", 64'(stall), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_lo", 64'(result_lo), 64'd0);
    chk("midrst_hi", 64'(result_hi), 64'd0);
    chk("midrst_dz", 64'(div_zero), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) begin @(posedge clk); #1; end

    // Randomized traffic, including divide by zero, back-to-back issue and flush during done
    for (int i = 0; i < 40; i++) begin
      bit isdiv;
      rand_src();
      ForwardA = 3'($urandom_range(0, 7));
      ForwardB = 3'($urandom_range(0, 7));
      isdiv = 1'($urandom_range(0, 1));
      if (isdiv && $urandom_range(0, 4) == 0) set_src(ForwardB, '0, 1'b1);
      run_op(isdiv, 1'($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (5) @(posedge clk);
    #1;
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
